// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   EX stage of the five-stage MIPS pipeline. It decodes the ID/EX register,
//   forwards operands from EX/MEM and MEM/WB, runs the ALU and registers the
//   EX/MEM register. An optional sequential multiplier provides HI/LO with
//   mult/multu/mfhi/mflo.
//
//   Configuration macro: EXEC_MULDIV_EN
//     defined   -> shift-add multiplier FSM, HI/LO registers, pipeline hold
//     undefined -> no multiplier; exHOLD tied low; funct 10/12/18/19 behave
//                  as undefined functs (result 0, controls passed through)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   IDEXReg   [135]RegDst [134]MemRead [133]MemtoReg [132:131]ALUOp
//             [130]MemWrite [129]ALUSrc [128]RegWrite [127:96]ext imm
//             [95:64]readData2 [63:32]readData1 [31:0]instruction
//   MEMWBReg  [70]MemtoReg [69:38]ALUresult [37]RegWrite [36:32]WriteReg
//             [31:0]ReadData
//   EXMEReg   [74]RegWrite [73]MemRead [72]MemtoReg [71]MemWrite [70]Zero
//             [69]Overflow [68:64]WriteReg [63:32]store data [31:0]ALUresult
//   exHOLD    combinational request to hold PC, IF/ID and ID/EX this cycle
// ---------------------------------------------------------------------------
module execute_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [135:0] IDEXReg,
  input  logic [70:0]  MEMWBReg,
  output logic [74:0]  EXMEReg,
  output logic         exHOLD
);

  logic        regDst, memRead, memToReg, memWrite, aluSrc, regWrite;
  logic [1:0]  aluOp;
  logic [31:0] extImm, readData1, readData2, instruction;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign regDst      = IDEXReg[135];
  assign memRead     = IDEXReg[134];
  assign memToReg    = IDEXReg[133];
  assign aluOp       = IDEXReg[132:131];
  assign memWrite    = IDEXReg[130];
  assign aluSrc      = IDEXReg[129];
  assign regWrite    = IDEXReg[128];
  assign extImm      = IDEXReg[127:96];
  assign readData2   = IDEXReg[95:64];
  assign readData1   = IDEXReg[63:32];
  assign instruction = IDEXReg[31:0];

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];

  logic [4:0] writeReg;
  assign writeReg = regDst ? rd : rt;

  logic        exMemRegWrite, memWbRegWrite;
  logic [4:0]  exMemWriteReg, memWbWriteReg;
  logic [31:0] exMemResult, memWbData;

  assign exMemRegWrite = EXMEReg[74];
  assign exMemWriteReg = EXMEReg[68:64];
  assign exMemResult   = EXMEReg[31:0];
  assign memWbRegWrite = MEMWBReg[37];
  assign memWbWriteReg = MEMWBReg[36:32];
  assign memWbData     = MEMWBReg[70] ? MEMWBReg[31:0] : MEMWBReg[69:38];

  // Operand forwarding: the younger EX/MEM result wins over MEM/WB, and $0
  // is never forwarded because it is hard-wired to zero in the register file.
  logic [31:0] operandA, operandB, aluB;

  always_comb begin
    operandA = readData1;
    if (exMemRegWrite && (exMemWriteReg != 5'd0) && (exMemWriteReg == rs))
      operandA = exMemResult;
    else if (memWbRegWrite && (memWbWriteReg != 5'd0) && (memWbWriteReg == rs))
      operandA = memWbData;
  end

  always_comb begin
    operandB = readData2;
    if (exMemRegWrite && (exMemWriteReg != 5'd0) && (exMemWriteReg == rt))
      operandB = exMemResult;
    else if (memWbRegWrite && (memWbWriteReg != 5'd0) && (memWbWriteReg == rt))
      operandB = memWbData;
  end

  assign aluB = aluSrc ? extImm : operandB;

  logic        isMult, bubble;
  logic [31:0] hi, lo;

`ifdef EXEC_MULDIV_EN
  typedef enum logic {IDLE, BUSY} mulState_t;
  mulState_t   state, nextState;
  logic [4:0]  count;
  logic [63:0] mcand, product, partial, finalProduct;
  logic [31:0] mplier, magA, magB;
  logic        negResult, signedMul, isMulDivOp;

  assign isMult     = (aluOp == 2'b10) && ((funct == 6'h18) || (funct == 6'h19));
  assign isMulDivOp = isMult || ((aluOp == 2'b10) && ((funct == 6'h10) || (funct == 6'h12)));
  assign signedMul  = (funct == 6'h18);

  // Signed multiply works on magnitudes and fixes the sign at the end, so
  // the iteration itself is always an unsigned shift-add.
  assign magA = (signedMul && operandA[31]) ? (~operandA + 32'd1) : operandA;
  assign magB = (signedMul && operandB[31]) ? (~operandB + 32'd1) : operandB;

  assign partial      = product + (mplier[0] ? mcand : 64'd0);
  assign finalProduct = negResult ? (~partial + 64'd1) : partial;

  assign exHOLD = (state == BUSY) && isMulDivOp;
  assign bubble = exHOLD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (isMult) nextState = BUSY;
      BUSY:    if (count == 5'd31) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // One partial product per BUSY cycle; HI/LO are written on the 32nd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 5'd0;
      mcand     <= 64'd0;
      mplier    <= 32'd0;
      product   <= 64'd0;
      negResult <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (isMult) begin
            count     <= 5'd0;
            mcand     <= {32'd0, magA};
            mplier    <= magB;
            product   <= 64'd0;
            negResult <= signedMul && (operandA[31] ^ operandB[31]);
          end
        end
        BUSY: begin
          product <= partial;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count + 5'd1;
          if (count == 5'd31) {hi, lo} <= finalProduct;
        end
        default: ;
      endcase
    end
  end
`else
  assign isMult = 1'b0;
  assign bubble = 1'b0;
  assign exHOLD = 1'b0;
  assign hi     = 32'd0;
  assign lo     = 32'd0;
`endif

  // ALU: unknown funct/opcode values fall to a zero result. Overflow is
  // reported only for the trapping add/sub/addi forms.
  logic [31:0] sum, diff, result;
  logic        addOvf, subOvf, overflow;

  assign sum    = operandA + aluB;
  assign diff   = operandA - aluB;
  assign addOvf = (operandA[31] == aluB[31]) && (sum[31]  != operandA[31]);
  assign subOvf = (operandA[31] != aluB[31]) && (diff[31] != operandA[31]);

  always_comb begin
    result   = 32'd0;
    overflow = 1'b0;
    case (aluOp)
      2'b00: result = sum;
      2'b01: result = diff;
      2'b10: begin
        case (funct)
          6'h20: begin result = sum;  overflow = addOvf; end
          6'h21: result = sum;
          6'h22: begin result = diff; overflow = subOvf; end
          6'h23: result = diff;
          6'h24: result = operandA & aluB;
          6'h25: result = operandA | aluB;
          6'h26: result = operandA ^ aluB;
          6'h27: result = ~(operandA | aluB);
          6'h2A: result = {31'd0, ($signed(operandA) < $signed(aluB))};
          6'h2B: result = {31'd0, (operandA < aluB)};
          6'h00: result = aluB << shamt;
          6'h02: result = aluB >> shamt;
          6'h03: result = $signed(aluB) >>> shamt;
`ifdef EXEC_MULDIV_EN
          6'h10: result = hi;
          6'h12: result = lo;
`endif
          default: result = 32'd0;
        endcase
      end
      2'b11: begin
        case (opcode)
          6'h08: begin result = sum; overflow = addOvf; end
          6'h09: result = sum;
          6'h0A: result = {31'd0, ($signed(operandA) < $signed(aluB))};
          6'h0C: result = operandA & {16'd0, imm16};
          6'h0D: result = operandA | {16'd0, imm16};
          6'h0F: result = {imm16, 16'd0};
          default: result = 32'd0;
        endcase
      end
      default: result = 32'd0;
    endcase
  end

  // mult/multu only start the multiplier, so they must not write the
  // register file or touch memory on their way down the pipe.
  logic [74:0] nextExMem;
  assign nextExMem = {regWrite & ~isMult, memRead & ~isMult, memToReg,
                      memWrite & ~isMult, (result == 32'd0), overflow,
                      writeReg, operandB, result};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      EXMEReg <= 75'd0;
    else if (bubble) EXMEReg <= 75'd0;
    else             EXMEReg <= nextExMem;
  end

endmodule
